// File: rtl/pwm_output_driver_pkg.sv
// Constants shared by the PWM output driver and the SPI register block.
package pwm_output_driver_pkg;

    localparam int unsigned      PWM_CNT_W     = 8;
    localparam logic [7:0]       PWM_DUTY_FULL = 8'hFF;
    localparam int unsigned      NUM_OUTPUTS   = 16;

    typedef enum logic [7:0] {
        ADDR_EN_OUT_7_0  = 8'h00,
        ADDR_EN_OUT_15_8 = 8'h01,
        ADDR_EN_PWM_7_0  = 8'h02,
        ADDR_EN_PWM_15_8 = 8'h03,
        ADDR_PWM_DUTY    = 8'h04
    } spi_reg_addr_e;

    // Full-scale duty is forced high so 0xFF really means 100 %.
    function automatic logic pwm_level(input logic [PWM_CNT_W-1:0] cnt,
                                       input logic [PWM_CNT_W-1:0] duty);
        return (duty == PWM_DUTY_FULL) ? 1'b1 : (cnt < duty);
    endfunction

endpackage

// File: rtl/pwm_output_driver_prescaler.sv
// Divides clk down to a one-cycle tick every CLK_DIV cycles.
module pwm_prescaler #(
    parameter int unsigned CLK_DIV = 13,
    parameter int unsigned PRE_W   = 4
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);

    localparam logic [PRE_W-1:0] LAST = PRE_W'(CLK_DIV - 1);

    logic [PRE_W-1:0] pre;

    // With CLK_DIV==1, LAST is zero: pre never leaves 0 and tick is constant high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre <= '0;
        end else if (pre == LAST) begin
            pre <= '0;
        end else begin
            pre <= pre + PRE_W'(1);
        end
    end

    assign tick = (pre == LAST);

endmodule

// File: rtl/pwm_output_driver.sv
// Drives the 16 chip outputs as off, static high, or PWM from a shadowed duty value.
module pwm_output_driver
    import pwm_output_driver_pkg::*;
#(
    parameter int unsigned CLK_DIV = 13,
    parameter int unsigned PRE_W   = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] en_reg_out_7_0,
    input  logic [7:0] en_reg_out_15_8,
    input  logic [7:0] en_reg_pwm_7_0,
    input  logic [7:0] en_reg_pwm_15_8,
    input  logic [7:0] pwm_duty_cycle,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic       period_start
);

    logic                   tick;
    logic [PWM_CNT_W-1:0]   pwm_cnt;
    logic [PWM_CNT_W-1:0]   duty_act;
    logic                   primed;
    logic                   wrap;
    logic                   pwm_sig;
    logic [NUM_OUTPUTS-1:0] en_out;
    logic [NUM_OUTPUTS-1:0] en_pwm;
    logic [NUM_OUTPUTS-1:0] out_d;

    pwm_prescaler #(
        .CLK_DIV (CLK_DIV),
        .PRE_W   (PRE_W)
    ) u_prescaler (
        .clk   (clk),
        .rst_n (rst_n),
        .tick  (tick)
    );

    assign wrap = tick && (pwm_cnt == '1);

    // Duty is sampled once right after reset, then only at the period wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pwm_cnt      <= '0;
            duty_act     <= '0;
            primed       <= 1'b0;
            period_start <= 1'b0;
            uo_out       <= '0;
            uio_out      <= '0;
        end else begin
            primed       <= 1'b1;
            period_start <= wrap;
            if (tick) begin
                pwm_cnt <= pwm_cnt + PWM_CNT_W'(1);
            end
            if (!primed || wrap) begin
                duty_act <= pwm_duty_cycle;
            end
            {uio_out, uo_out} <= out_d;
        end
    end

    always_comb begin
        en_out  = {en_reg_out_15_8, en_reg_out_7_0};
        en_pwm  = {en_reg_pwm_15_8, en_reg_pwm_7_0};
        pwm_sig = pwm_level(pwm_cnt, duty_act);
        out_d   = '0;
        for (int unsigned i = 0; i < NUM_OUTPUTS; i++) begin
            out_d[i] = en_out[i] & (en_pwm[i] ? pwm_sig : 1'b1);
        end
    end

endmodule

// File: tb/tb_pwm_output_driver.sv
// Directed bench for pwm_output_driver at CLK_DIV=4 (1024-cycle PWM period).
module tb_pwm_output_driver;

    logic       clk;
    logic       rst_n;
    logic [7:0] en_out_lo, en_out_hi, en_pwm_lo, en_pwm_hi, duty;
    logic [7:0] uo_out, uio_out;
    logic       period_start;

    int checks   = 0;
    int failures = 0;

    pwm_output_driver #(
        .CLK_DIV (4),
        .PRE_W   (2)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .en_reg_out_7_0  (en_out_lo),
        .en_reg_out_15_8 (en_out_hi),
        .en_reg_pwm_7_0  (en_pwm_lo),
        .en_reg_pwm_15_8 (en_pwm_hi),
        .pwm_duty_cycle  (duty),
        .uo_out          (uo_out),
        .uio_out         (uio_out),
        .period_start    (period_start)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Samples 1024 negedges; the output at sample k reflects pwm_cnt of cycle k-1.
    task automatic run_period(input int chg_k, input logic [7:0] chg_duty,
                              output int high, output int ps_cnt, output logic ps_last,
                              output logic v1, output logic v2, output logic v513,
                              output logic [14:0] others);
        high = 0; ps_cnt = 0; others = '0; v1 = 1'b0; v2 = 1'b0; v513 = 1'b0;
        for (int k = 1; k <= 1024; k++) begin
            @(negedge clk);
            if (uo_out[0]) high++;
            if (period_start) ps_cnt++;
            if (k == 1) v1 = uo_out[0];
            if (k == 2) v2 = uo_out[0];
            if (k == 513) v513 = uo_out[0];
            others |= {uio_out, uo_out[7:1]};
            if (k == chg_k) duty = chg_duty;
        end
        ps_last = period_start;
    endtask

    initial begin
        int          high, ps_cnt, n;
        logic        ps_last, v1, v2, v513;
        logic [14:0] others;

        // 1: reset held with every input at 0xFF
        rst_n = 1'b0;
        en_out_lo = 8'hFF; en_out_hi = 8'hFF; en_pwm_lo = 8'hFF; en_pwm_hi = 8'hFF; duty = 8'hFF;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rst_uo", {8'h0, uo_out}, 16'h0000);
            check("rst_uio", {8'h0, uio_out}, 16'h0000);
            check("rst_ps", {15'h0, period_start}, 16'h0000);
        end

        // 2: static enables, then narrow the low byte
        en_pwm_lo = 8'h00; en_pwm_hi = 8'h00; duty = 8'h00;
        rst_n = 1'b1;
        @(negedge clk);
        check("static_all", {uio_out, uo_out}, 16'hFFFF);
        en_out_lo = 8'h0F;
        #1 check("static_pre_edge", {8'h0, uo_out}, 16'h00FF);
        @(negedge clk);
        check("static_lo_0f", {8'h0, uo_out}, 16'h000F);
        check("static_hi_keep", {8'h0, uio_out}, 16'h00FF);

        // 3: bit 0 in PWM at duty 0x80
        en_out_lo = 8'h01; en_out_hi = 8'h00; en_pwm_lo = 8'h01; duty = 8'h80;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!period_start && n < 3000);
        check("wait_period_start", {15'h0, period_start}, 16'h0001);
        run_period(0, 8'h00, high, ps_cnt, ps_last, v1, v2, v513, others);
        check("d80_high", 16'(high), 16'd512);
        check("d80_rise", {15'h0, v1}, 16'h0001);
        check("d80_fall", {15'h0, v513}, 16'h0000);
        check("d80_others", {1'b0, others}, 16'h0000);
        check("d80_ps_once", 16'(ps_cnt), 16'd1);
        check("d80_ps_end", {15'h0, ps_last}, 16'h0001);

        // 4: duty 0x00, then 0xFF; each change waits for the next wrap
        duty = 8'h00;
        run_period(0, 8'h00, high, ps_cnt, ps_last, v1, v2, v513, others);
        check("d80_held", 16'(high), 16'd512);
        duty = 8'hFF;
        run_period(0, 8'h00, high, ps_cnt, ps_last, v1, v2, v513, others);
        check("d00_high", 16'(high), 16'd0);
        run_period(0, 8'h00, high, ps_cnt, ps_last, v1, v2, v513, others);
        check("dff_high", 16'(high), 16'd1024);

        // 5: 0x40 period with 0xC0 written at pwm_cnt=0x30
        duty = 8'h40;
        run_period(0, 8'h00, high, ps_cnt, ps_last, v1, v2, v513, others);
        check("dff_wrap_high", 16'(high), 16'd1024);
        run_period(193, 8'hC0, high, ps_cnt, ps_last, v1, v2, v513, others);
        check("d40_kept", 16'(high), 16'd256);
        check("d40_ps_once", 16'(ps_cnt), 16'd1);
        en_out_lo = 8'h03; duty = 8'h80;
        run_period(0, 8'h00, high, ps_cnt, ps_last, v1, v2, v513, others);
        check("dc0_high", 16'(high), 16'd768);

        // 6: reset pulse at pwm_cnt=0x90 in a duty 0x80 period
        repeat (577) @(negedge clk);
        check("pre_rst_uo", {8'h0, uo_out}, 16'h0002);
        #1 rst_n = 1'b0;
        #1 check("async_rst_uo", {8'h0, uo_out}, 16'h0000);
        repeat (2) @(negedge clk);
        check("rst_hold_uo", {8'h0, uo_out}, 16'h0000);
        check("rst_hold_ps", {15'h0, period_start}, 16'h0000);
        rst_n = 1'b1;
        run_period(0, 8'h00, high, ps_cnt, ps_last, v1, v2, v513, others);
        check("restart_first", {15'h0, v1}, 16'h0000);
        check("restart_second", {15'h0, v2}, 16'h0001);
        check("restart_high", 16'(high), 16'd511);
        check("restart_fall", {15'h0, v513}, 16'h0000);
        check("restart_ps_once", 16'(ps_cnt), 16'd1);
        check("restart_ps_end", {15'h0, ps_last}, 16'h0001);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
